// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one combinational logical-right-shift unit between two requesters:
//   requester 0 : EX-stage ALU path
//   requester 1 : multi-cycle mul/div unit
// Requests are arbitrated round-robin. The winner's operands feed the Shifter
// and the result lands in a one-entry output slot that is handed back to the
// winner over a valid/ready handshake.
//
// Ports
//   clk                      rising-edge clock for all state
//   reset                    synchronous, active-high
//   req0_* / req1_*          request channel: valid/ready, dataA, shamt, signal
//   resp0_* / resp1_*        response channel: valid (out), ready (in)
//   resp_data                slot contents, shared by both response ports
//   last_grant               ID of the most recently accepted requester (debug)
//
// Parameters
//   DW        data width; the Shifter is fixed at 32 bits, so DW must be 32
//   SRL_CODE  signal value selecting the logical right shift; other values
//             pass dataA through unchanged
// -----------------------------------------------------------------------------

// Combinational barrel shifter. The reset input forces a zero result; in this
// design it is tied low so the shifter is purely a function of its operands.
module Shifter #(
   parameter int         DW       = 32,
   parameter logic [3:0] SRL_CODE = 4'b0011
) (
   input  logic          reset,
   input  logic [DW-1:0] dataA,
   input  logic [4:0]    shamt,
   input  logic [3:0]    signal,
   output logic [DW-1:0] result
);

   always_comb begin
      result = dataA;
      if (reset) begin
         result = '0;
      end else if (signal == SRL_CODE) begin
         result = dataA >> shamt;   // zero fill from the top
      end
   end

endmodule

module shift_arbiter #(
   parameter int         DW       = 32,
   parameter logic [3:0] SRL_CODE = 4'b0011
) (
   input  logic          clk,
   input  logic          reset,

   // requester 0 (ALU path)
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_dataA,
   input  logic [4:0]    req0_shamt,
   input  logic [3:0]    req0_signal,
   output logic          resp0_valid,
   input  logic          resp0_ready,

   // requester 1 (mul/div unit)
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_dataA,
   input  logic [4:0]    req1_shamt,
   input  logic [3:0]    req1_signal,
   output logic          resp1_valid,
   input  logic          resp1_ready,

   // shared response data and debug
   output logic [DW-1:0] resp_data,
   output logic          last_grant
);

   // ---------------------------------------------------------------------------
   // Output slot and arbitration state
   // ---------------------------------------------------------------------------
   logic          slotValidReg;
   logic          slotOwnerReg;
   logic [DW-1:0] slotDataReg;
   logic          lastGrantReg;

   // ---------------------------------------------------------------------------
   // Slot availability
   // ---------------------------------------------------------------------------
   logic ownerReady;
   logic slotDrain;
   logic slotFree;

   // The slot can take a new result if it is empty, or if its current owner is
   // consuming the held result on this same edge (drain + refill together).
   assign ownerReady = slotOwnerReg ? resp1_ready : resp0_ready;
   assign slotDrain  = slotValidReg & ownerReady;
   assign slotFree   = !slotValidReg | ownerReady;

   // ---------------------------------------------------------------------------
   // Round-robin arbitration
   // ---------------------------------------------------------------------------
   logic anyReq;
   logic grantId;
   logic accept;

   always_comb begin
      grantId = 1'b0;
      if (req0_valid && req1_valid) begin
         // contention: favour whoever did not win last time
         grantId = !lastGrantReg;
      end else if (req1_valid) begin
         grantId = 1'b1;
      end else begin
         grantId = 1'b0;
      end
   end

   assign anyReq = req0_valid | req1_valid;

   // Nothing is accepted while reset is asserted, even though the slot state
   // itself only clears on the edge.
   assign accept = slotFree & anyReq & !reset;

   assign req0_ready = accept & (grantId == 1'b0);
   assign req1_ready = accept & (grantId == 1'b1);

   // ---------------------------------------------------------------------------
   // Datapath: mux the granted operands into the shared Shifter
   // ---------------------------------------------------------------------------
   logic [DW-1:0] muxDataA;
   logic [4:0]    muxShamt;
   logic [3:0]    muxSignal;
   logic [DW-1:0] shiftResult;

   always_comb begin
      muxDataA  = req0_dataA;
      muxShamt  = req0_shamt;
      muxSignal = req0_signal;
      if (grantId) begin
         muxDataA  = req1_dataA;
         muxShamt  = req1_shamt;
         muxSignal = req1_signal;
      end
   end

   Shifter #(
      .DW       (DW),
      .SRL_CODE (SRL_CODE)
   ) shifterInst (
      .reset  (1'b0),
      .dataA  (muxDataA),
      .shamt  (muxShamt),
      .signal (muxSignal),
      .result (shiftResult)
   );

   // ---------------------------------------------------------------------------
   // Slot update
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         slotValidReg <= 1'b0;
         slotOwnerReg <= 1'b0;
         slotDataReg  <= '0;
         lastGrantReg <= 1'b1;   // requester 0 wins the first contention
      end else if (accept) begin
         slotValidReg <= 1'b1;
         slotOwnerReg <= grantId;
         slotDataReg  <= shiftResult;
         lastGrantReg <= grantId;
      end else if (slotDrain) begin
         // data is left in place; it is meaningless once valid drops
         slotValidReg <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Responses
   // ---------------------------------------------------------------------------
   // Gating with reset hides a pending result during the reset cycle; that
   // result is then discarded on the edge.
   assign resp0_valid = slotValidReg & (slotOwnerReg == 1'b0) & !reset;
   assign resp1_valid = slotValidReg & (slotOwnerReg == 1'b1) & !reset;
   assign resp_data   = slotDataReg;
   assign last_grant  = lastGrantReg;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Directed bench for shift_arbiter. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 further unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_dataA, req1_dataA;
   logic [4:0]  req0_shamt, req1_shamt;
   logic [3:0]  req0_signal, req1_signal;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready, resp1_ready;
   logic [31:0] resp_data;
   logic        last_grant;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   shift_arbiter #(
      .DW       (32),
      .SRL_CODE (4'b0011)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_dataA  (req0_dataA),
      .req0_shamt  (req0_shamt),
      .req0_signal (req0_signal),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_dataA  (req1_dataA),
      .req1_shamt  (req1_shamt),
      .req1_signal (req1_signal),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp_data   (resp_data),
      .last_grant  (last_grant)
   );

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle after an input change
   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] allOnes;
   logic [31:0] expShift;
   logic        expGrant;

   initial begin
      allOnes     = 32'hFFFF_FFFF;
      reset       = 1'b1;
      req0_valid  = 1'b1;   // present during reset: must not be accepted
      req1_valid  = 1'b0;
      req0_dataA  = 32'h0;
      req1_dataA  = 32'h0;
      req0_shamt  = 5'd0;
      req1_shamt  = 5'd0;
      req0_signal = 4'd0;
      req1_signal = 4'd0;
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;

      // ---------------- reset state ----------------
      tick();
      chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      chk("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
      chk("rst_last_grant", {31'b0, last_grant}, 32'd1);
      chk("rst_resp_data", resp_data, 32'h0);
      tick();

      // ---------------- single req0 SRL ----------------
      reset       = 1'b0;
      req0_valid  = 1'b1;
      req0_dataA  = 32'h8000_0000;
      req0_shamt  = 5'd31;
      req0_signal = 4'b0011;
      resp0_ready = 1'b1;
      settle();
      chk("t1_req0_ready", {31'b0, req0_ready}, 32'd1);
      chk("t1_req1_ready", {31'b0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      settle();
      chk("t1_resp0_valid", {31'b0, resp0_valid}, 32'd1);
      chk("t1_resp_data", resp_data, 32'h0000_0001);
      chk("t1_last_grant", {31'b0, last_grant}, 32'd0);
      tick();
      chk("t1_resp0_drained", {31'b0, resp0_valid}, 32'd0);

      // ---------------- single req1 pass-through ----------------
      req1_valid  = 1'b1;
      req1_dataA  = 32'hDEAD_BEEF;
      req1_shamt  = 5'd7;
      req1_signal = 4'b0000;
      resp1_ready = 1'b1;
      settle();
      chk("t2_req1_ready", {31'b0, req1_ready}, 32'd1);
      chk("t2_resp0_valid_a", {31'b0, resp0_valid}, 32'd0);
      tick();
      req1_valid = 1'b0;
      settle();
      chk("t2_resp1_valid", {31'b0, resp1_valid}, 32'd1);
      chk("t2_resp_data", resp_data, 32'hDEAD_BEEF);
      chk("t2_resp0_valid_b", {31'b0, resp0_valid}, 32'd0);
      chk("t2_last_grant", {31'b0, last_grant}, 32'd1);
      tick();
      chk("t2_resp1_drained", {31'b0, resp1_valid}, 32'd0);

      // ---------------- contention, round-robin ----------------
      req0_valid  = 1'b1;
      req1_valid  = 1'b1;
      req1_dataA  = 32'h1234_5678;
      req1_shamt  = 5'd0;
      req1_signal = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         expGrant = (i % 2 == 1);
         if (i == 0) begin
            req0_dataA  = 32'hF000_0000;
            req0_shamt  = 5'd4;
            req0_signal = 4'b0011;
         end else begin
            req0_dataA  = 32'h0000_00F0;
            req0_shamt  = 5'd4;
            req0_signal = 4'b0011;
         end
         settle();
         chk($sformatf("rr%0d_req0_ready", i), {31'b0, req0_ready}, {31'b0, !expGrant});
         chk($sformatf("rr%0d_req1_ready", i), {31'b0, req1_ready}, {31'b0, expGrant});
         tick();
         chk($sformatf("rr%0d_last_grant", i), {31'b0, last_grant}, {31'b0, expGrant});
         chk($sformatf("rr%0d_resp0_valid", i), {31'b0, resp0_valid}, {31'b0, !expGrant});
         chk($sformatf("rr%0d_resp1_valid", i), {31'b0, resp1_valid}, {31'b0, expGrant});
         if (i == 0) chk("rr0_resp_data", resp_data, 32'h0F00_0000);
         if (i == 1) chk("rr1_resp_data", resp_data, 32'h1234_5678);
         if (i == 2) chk("rr2_resp_data", resp_data, 32'h0000_000F);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      chk("rr_drained", {30'b0, resp1_valid, resp0_valid}, 32'd0);

      // ---------------- back-pressure ----------------
      req0_valid  = 1'b1;
      req0_dataA  = 32'h0000_0100;
      req0_shamt  = 5'd8;
      req0_signal = 4'b0011;
      resp0_ready = 1'b0;
      settle();
      chk("bp_req0_ready", {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid  = 1'b0;
      req1_valid  = 1'b1;
      req1_dataA  = 32'hCAFE_F00D;
      req1_shamt  = 5'd0;
      req1_signal = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("bp%0d_req1_ready", i), {31'b0, req1_ready}, 32'd0);
         chk($sformatf("bp%0d_resp0_valid", i), {31'b0, resp0_valid}, 32'd1);
         chk($sformatf("bp%0d_resp_data", i), resp_data, 32'h0000_0001);
         tick();
      end
      resp0_ready = 1'b1;
      settle();
      chk("bp_release_req1_ready", {31'b0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      settle();
      chk("bp_resp1_valid", {31'b0, resp1_valid}, 32'd1);
      chk("bp_resp0_valid", {31'b0, resp0_valid}, 32'd0);
      chk("bp_resp_data", resp_data, 32'hCAFE_F00D);
      tick();

      // ---------------- reset with a pending result ----------------
      req0_valid  = 1'b1;
      req0_dataA  = 32'hAAAA_5555;
      req0_signal = 4'b0000;
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      tick();
      req0_valid = 1'b0;
      settle();
      chk("mr_pending", {31'b0, resp0_valid}, 32'd1);
      reset      = 1'b1;
      req1_valid = 1'b1;
      resp0_ready = 1'b1;
      settle();
      chk("mr_req1_ready_in_reset", {31'b0, req1_ready}, 32'd0);
      chk("mr_resp0_valid_in_reset", {31'b0, resp0_valid}, 32'd0);
      tick();
      reset       = 1'b0;
      req1_valid  = 1'b0;
      resp0_ready = 1'b0;
      settle();
      chk("mr_resp_valid_after", {30'b0, resp1_valid, resp0_valid}, 32'd0);
      chk("mr_last_grant", {31'b0, last_grant}, 32'd1);
      req0_valid  = 1'b1;
      req1_valid  = 1'b1;
      req0_dataA  = 32'h0000_0042;
      req0_signal = 4'b0000;
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      settle();
      chk("mr_first_req0_ready", {31'b0, req0_ready}, 32'd1);
      chk("mr_first_req1_ready", {31'b0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      settle();
      chk("mr_first_resp0", {31'b0, resp0_valid}, 32'd1);
      chk("mr_first_data", resp_data, 32'h0000_0042);
      tick();

      // ---------------- shift sweep, back-to-back on req0 ----------------
      req0_valid  = 1'b1;
      req0_dataA  = 32'hFFFF_FFFF;
      req0_signal = 4'b0011;
      resp0_ready = 1'b1;
      for (int s = 0; s < 32; s++) begin
         req0_shamt = 5'(s);
         expShift   = allOnes >> s;
         tick();
         chk($sformatf("sweep_shamt%0d", s), resp_data, expShift);
      end
      // a non-SRL code must pass dataA through regardless of shamt
      req0_shamt  = 5'd5;
      req0_signal = 4'b0010;
      tick();
      req0_valid = 1'b0;
      settle();
      chk("sweep_other_code", resp_data, 32'hFFFF_FFFF);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
